// File: rtl/axis_frame_source.sv
// Command-driven AXI-Stream frame generator: one frame of incrementing data per
// accepted command, with fixed tid/tdest, optional bad-frame tuser and an idle gap.
module axis_frame_source #(
    parameter int DATA_WIDTH = 8,
    parameter int ID_WIDTH   = 8,
    parameter int DEST_WIDTH = 8,
    parameter int USER_WIDTH = 1,
    parameter int LEN_WIDTH  = 16,
    parameter int GAP_WIDTH  = 8,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    input  logic [DATA_WIDTH-1:0] cmd_seed,
    input  logic [ID_WIDTH-1:0]   cmd_id,
    input  logic [DEST_WIDTH-1:0] cmd_dest,
    input  logic                  cmd_bad,
    input  logic [GAP_WIDTH-1:0]  cmd_gap,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic [ID_WIDTH-1:0]   m_axis_tid,
    output logic [DEST_WIDTH-1:0] m_axis_tdest,
    output logic [USER_WIDTH-1:0] m_axis_tuser,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  frame_count,
    output logic [CNT_WIDTH-1:0]  beat_count
);

    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

    state_t               state;
    logic [LEN_WIDTH-1:0] remaining;
    logic [GAP_WIDTH-1:0] gap_cnt;
    logic [GAP_WIDTH-1:0] gap_lat;
    logic                 bad_lat;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cmd_ready     <= 1'b0;
            busy          <= 1'b0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tuser  <= '0;
            m_axis_tdata  <= '0;
            m_axis_tid    <= '0;
            m_axis_tdest  <= '0;
            frame_count   <= '0;
            beat_count    <= '0;
            remaining     <= '0;
            gap_cnt       <= '0;
            gap_lat       <= '0;
            bad_lat       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // cmd_ready is held low for the cycle right after reset
                    cmd_ready <= 1'b1;
                    if (cmd_valid && cmd_ready) begin
                        state         <= SEND;
                        cmd_ready     <= 1'b0;
                        busy          <= 1'b1;
                        m_axis_tvalid <= 1'b1;
                        m_axis_tdata  <= cmd_seed;
                        m_axis_tid    <= cmd_id;
                        m_axis_tdest  <= cmd_dest;
                        m_axis_tlast  <= (cmd_len == '0);
                        m_axis_tuser  <= {USER_WIDTH{cmd_bad && (cmd_len == '0)}};
                        remaining     <= cmd_len;
                        bad_lat       <= cmd_bad;
                        gap_lat       <= cmd_gap;
                    end
                end
                SEND: begin
                    if (m_axis_tready) begin
                        beat_count   <= beat_count + CNT_WIDTH'(1);
                        m_axis_tdata <= m_axis_tdata + DATA_WIDTH'(1);
                        if (m_axis_tlast) begin
                            frame_count   <= frame_count + CNT_WIDTH'(1);
                            m_axis_tvalid <= 1'b0;
                            m_axis_tlast  <= 1'b0;
                            m_axis_tuser  <= '0;
                            if (gap_lat != '0) begin
                                state   <= GAP;
                                gap_cnt <= gap_lat;
                            end else begin
                                state     <= IDLE;
                                cmd_ready <= 1'b1;
                                busy      <= 1'b0;
                            end
                        end else begin
                            // Next beat is last once remaining steps down to zero
                            remaining    <= remaining - LEN_WIDTH'(1);
                            m_axis_tlast <= (remaining == LEN_WIDTH'(1));
                            m_axis_tuser <= {USER_WIDTH{bad_lat && (remaining == LEN_WIDTH'(1))}};
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_WIDTH'(1)) begin
                        state     <= IDLE;
                        cmd_ready <= 1'b1;
                        busy      <= 1'b0;
                    end else begin
                        gap_cnt <= gap_cnt - GAP_WIDTH'(1);
                    end
                end
                default: begin
                    state     <= IDLE;
                    cmd_ready <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axis_frame_source.sv
// Directed self-checking bench for axis_frame_source; inputs driven and outputs
// sampled on the falling clock edge.
module tb_axis_frame_source;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] cmd_len;
    logic [7:0]  cmd_seed;
    logic [7:0]  cmd_id;
    logic [7:0]  cmd_dest;
    logic        cmd_bad;
    logic [7:0]  cmd_gap;
    logic [7:0]  m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        m_axis_tlast;
    logic [7:0]  m_axis_tid;
    logic [7:0]  m_axis_tdest;
    logic [0:0]  m_axis_tuser;
    logic        busy;
    logic [31:0] frame_count;
    logic [31:0] beat_count;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    axis_frame_source dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
        .cmd_seed(cmd_seed), .cmd_id(cmd_id), .cmd_dest(cmd_dest),
        .cmd_bad(cmd_bad), .cmd_gap(cmd_gap),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
        .m_axis_tid(m_axis_tid), .m_axis_tdest(m_axis_tdest),
        .m_axis_tuser(m_axis_tuser), .busy(busy),
        .frame_count(frame_count), .beat_count(beat_count)
    );

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Present a command and hold it until accepted; returns at the negedge after the accept edge.
    task automatic send_cmd(input logic [15:0] len, input logic [7:0] seed, input logic [7:0] id,
                            input logic [7:0] dest, input logic bad, input logic [7:0] gap);
        bit ok = 0;
        cmd_len = len; cmd_seed = seed; cmd_id = id; cmd_dest = dest; cmd_bad = bad; cmd_gap = gap;
        cmd_valid = 1'b1;
        for (int i = 0; i < 200 && !ok; i++) begin
            if (cmd_ready) ok = 1;
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        if (!ok) begin
            errors++;
            $display("FAIL send_cmd: cmd_ready never seen, actual=0 required=1");
        end
    endtask

    task automatic test_reset();
        cmd_valid = 0; m_axis_tready = 0; rst = 1'b1;
        @(negedge clk);
        vectors++;
        if ({cmd_ready, m_axis_tvalid, m_axis_tlast, m_axis_tuser, busy} !== 5'b0 ||
            m_axis_tdata !== 8'h00 || m_axis_tid !== 8'h00 || m_axis_tdest !== 8'h00 ||
            frame_count !== 32'd0 || beat_count !== 32'd0) begin
            errors++;
            $display("FAIL reset_state: rdy=%b v=%b l=%b u=%b busy=%b d=%h fc=%0d bc=%0d, required all zero",
                     cmd_ready, m_axis_tvalid, m_axis_tlast, m_axis_tuser, busy, m_axis_tdata,
                     frame_count, beat_count);
        end
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (cmd_ready !== 1'b1) begin
            errors++; $display("FAIL reset_ready: actual=%b required=1", cmd_ready);
        end
    endtask

    task automatic test_single_beat();
        do_reset();
        m_axis_tready = 1'b1;
        send_cmd(16'd0, 8'h01, 8'h01, 8'h00, 1'b0, 8'd0);
        vectors++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 8'h01 || m_axis_tlast !== 1'b1 ||
            m_axis_tuser !== 1'b0 || m_axis_tid !== 8'h01 || cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL single_beat: v=%b d=%h l=%b u=%b id=%h rdy=%b, required v=1 d=01 l=1 u=0 id=01 rdy=0",
                     m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tuser, m_axis_tid, cmd_ready);
        end
        @(negedge clk);
        vectors++;
        if (m_axis_tvalid !== 1'b0 || frame_count !== 32'd1 || beat_count !== 32'd1 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL single_counts: v=%b fc=%0d bc=%0d rdy=%b, required v=0 fc=1 bc=1 rdy=1",
                     m_axis_tvalid, frame_count, beat_count, cmd_ready);
        end
    endtask

    task automatic test_backpressure();
        logic [6:0] pat = 7'b1011001;   // bit i is tready in cycle i: 1,0,0,1,1,0,1
        logic [7:0] exp_d [4] = '{8'h10, 8'h11, 8'h12, 8'h13};
        logic [10:0] snap;
        bit stalled = 0;
        int k = 0;
        do_reset();
        m_axis_tready = 1'b0;
        send_cmd(16'd3, 8'h10, 8'h05, 8'h06, 1'b0, 8'd0);
        for (int i = 0; i < 7; i++) begin
            m_axis_tready = pat[i];
            if (stalled) begin
                vectors++;
                if ({m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tuser} !== snap) begin
                    errors++;
                    $display("FAIL stall_hold cyc%0d: actual=%h required=%h", i,
                             {m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tuser}, snap);
                end
            end
            stalled = m_axis_tvalid && !pat[i];
            snap = {m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tuser};
            if (m_axis_tvalid && pat[i] && k < 4) begin
                vectors++;
                if (m_axis_tdata !== exp_d[k] || m_axis_tlast !== (k == 3) ||
                    m_axis_tid !== 8'h05 || m_axis_tdest !== 8'h06) begin
                    errors++;
                    $display("FAIL bp_beat%0d: d=%h l=%b id=%h dest=%h, required d=%h l=%b id=05 dest=06",
                             k, m_axis_tdata, m_axis_tlast, m_axis_tid, m_axis_tdest, exp_d[k], (k == 3));
                end
                k++;
            end
            @(negedge clk);
        end
        vectors++;
        if (k != 4 || beat_count !== 32'd4 || m_axis_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL bp_count: beats=%0d bc=%0d v=%b, required beats=4 bc=4 v=0", k, beat_count, m_axis_tvalid);
        end
    endtask

    task automatic test_wrap_bad();
        logic [7:0] exp_d [3] = '{8'hFE, 8'hFF, 8'h00};
        do_reset();
        m_axis_tready = 1'b1;
        send_cmd(16'd2, 8'hFE, 8'h02, 8'h03, 1'b1, 8'd0);
        for (int k = 0; k < 3; k++) begin
            vectors++;
            if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== exp_d[k] || m_axis_tlast !== (k == 2) ||
                m_axis_tuser !== 1'(k == 2)) begin
                errors++;
                $display("FAIL wrap_beat%0d: v=%b d=%h l=%b u=%b, required v=1 d=%h l=%b u=%b",
                         k, m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tuser, exp_d[k], (k == 2), (k == 2));
            end
            @(negedge clk);
        end
        vectors++;
        if (m_axis_tvalid !== 1'b0 || m_axis_tuser !== 1'b0 || frame_count !== 32'd1) begin
            errors++;
            $display("FAIL wrap_end: v=%b u=%b fc=%0d, required v=0 u=0 fc=1", m_axis_tvalid, m_axis_tuser, frame_count);
        end
    endtask

    task automatic test_back_to_back();
        logic [11:0] exp_v = 12'b000000110110;  // bit c = expected tvalid in cycle c
        logic [11:0] exp_r = 12'b111000001001;  // bit c = expected cmd_ready in cycle c
        bit pend = 0;
        int issued = 0;
        do_reset();
        m_axis_tready = 1'b1;
        cmd_len = 16'd1; cmd_seed = 8'h30; cmd_id = 8'h0A; cmd_dest = 8'h0B; cmd_bad = 0; cmd_gap = 8'd0;
        cmd_valid = 1'b1;
        for (int c = 0; c < 12; c++) begin
            if (pend) begin
                pend = 0; issued++;
                if (issued == 1) begin
                    cmd_seed = 8'h40; cmd_gap = 8'd3;
                end else begin
                    cmd_valid = 1'b0;
                end
            end
            vectors++;
            if (m_axis_tvalid !== exp_v[c] || cmd_ready !== exp_r[c]) begin
                errors++;
                $display("FAIL b2b_cyc%0d: v=%b rdy=%b, required v=%b rdy=%b",
                         c, m_axis_tvalid, cmd_ready, exp_v[c], exp_r[c]);
            end
            if (cmd_valid && cmd_ready) pend = 1;
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        vectors++;
        if (frame_count !== 32'd2 || beat_count !== 32'd4) begin
            errors++;
            $display("FAIL b2b_counts: fc=%0d bc=%0d, required fc=2 bc=4", frame_count, beat_count);
        end
    endtask

    task automatic test_reset_mid_frame();
        bit saw_last = 0;
        do_reset();
        m_axis_tready = 1'b1;
        send_cmd(16'd5, 8'h20, 8'h01, 8'h01, 1'b0, 8'd0);
        for (int k = 0; k < 2; k++) begin
            if (m_axis_tlast) saw_last = 1;
            @(negedge clk);
        end
        vectors++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 8'h22) begin
            errors++;
            $display("FAIL rmid_beat3: v=%b d=%h, required v=1 d=22", m_axis_tvalid, m_axis_tdata);
        end
        if (m_axis_tlast) saw_last = 1;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        vectors++;
        if (m_axis_tvalid !== 1'b0 || m_axis_tlast !== 1'b0 || saw_last || frame_count !== 32'd0 ||
            beat_count !== 32'd0 || cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL rmid_abort: v=%b l=%b seen_last=%b fc=%0d bc=%0d rdy=%b, required all 0",
                     m_axis_tvalid, m_axis_tlast, saw_last, frame_count, beat_count, cmd_ready);
        end
        @(negedge clk);
        vectors++;
        if (cmd_ready !== 1'b1 || m_axis_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL rmid_ready: rdy=%b v=%b, required rdy=1 v=0", cmd_ready, m_axis_tvalid);
        end
        send_cmd(16'd1, 8'h50, 8'h07, 8'h08, 1'b0, 8'd0);
        vectors++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 8'h50 || m_axis_tlast !== 1'b0) begin
            errors++;
            $display("FAIL rmid_next0: v=%b d=%h l=%b, required v=1 d=50 l=0", m_axis_tvalid, m_axis_tdata, m_axis_tlast);
        end
        @(negedge clk);
        vectors++;
        if (m_axis_tdata !== 8'h51 || m_axis_tlast !== 1'b1) begin
            errors++;
            $display("FAIL rmid_next1: d=%h l=%b, required d=51 l=1", m_axis_tdata, m_axis_tlast);
        end
        @(negedge clk);
        vectors++;
        if (frame_count !== 32'd1 || beat_count !== 32'd2) begin
            errors++;
            $display("FAIL rmid_counts: fc=%0d bc=%0d, required fc=1 bc=2", frame_count, beat_count);
        end
    endtask

    task automatic test_sink_frames();
        logic [15:0] lens [4] = '{16'd0, 16'd0, 16'd0, 16'd5};
        bit drained;
        do_reset();
        m_axis_tready = 1'b1;
        for (int f = 0; f < 4; f++) begin
            send_cmd(lens[f], 8'(f * 16), 8'h00, 8'h00, 1'b0, 8'd0);
            drained = 0;
            for (int i = 0; i < 50 && !drained; i++) begin
                if (!m_axis_tvalid && !busy) drained = 1;
                else @(negedge clk);
            end
            if (!drained) begin
                errors++;
                $display("FAIL sink_drain%0d: frame still active after 50 cycles, required idle", f);
            end
        end
        vectors++;
        if (frame_count !== 32'd4 || beat_count !== 32'd9) begin
            errors++;
            $display("FAIL sink_counts: fc=%0d bc=%0d, required fc=4 bc=9", frame_count, beat_count);
        end
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 0; m_axis_tready = 0;
        cmd_len = '0; cmd_seed = '0; cmd_id = '0; cmd_dest = '0; cmd_bad = 0; cmd_gap = '0;
        @(negedge clk);
        test_reset();
        test_single_beat();
        test_backpressure();
        test_wrap_bad();
        test_back_to_back();
        test_reset_mid_frame();
        test_sink_frames();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/axis_frame_source.md
Name: axis_frame_source

Overview:
- Command-driven AXI-Stream frame generator; the transmitting end of an AXI-Stream link.
- Per accepted command it emits one frame of incrementing data with fixed tid/tdest and an optional bad-frame tuser mark on the last beat.
- Fully honours tready backpressure.
- Drives frame FIFOs and other AXIS sinks in benches and in on-chip loopback/self-test paths.

Parameters:
- DATA_WIDTH, 8, tdata width in bits
- ID_WIDTH, 8, tid width
- DEST_WIDTH, 8, tdest width
- USER_WIDTH, 1, tuser width
- LEN_WIDTH, 16, width of the frame length field
- GAP_WIDTH, 8, width of the inter-frame idle count
- CNT_WIDTH, 32, width of the status counters

Ports:
- clk  in  1  single clock; all logic on the rising edge
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accept
- cmd_len  in  LEN_WIDTH  frame length minus one (0 = 1 beat)
- cmd_seed  in  DATA_WIDTH  tdata of the first beat
- cmd_id  in  ID_WIDTH  tid for the whole frame
- cmd_dest  in  DEST_WIDTH  tdest for the whole frame
- cmd_bad  in  1  mark the frame bad via tuser on the last beat
- cmd_gap  in  GAP_WIDTH  idle cycles forced after the frame
- m_axis_tdata  out  DATA_WIDTH  stream data
- m_axis_tvalid  out  1  stream valid
- m_axis_tready  in  1  stream ready
- m_axis_tlast  out  1  last beat of frame
- m_axis_tid  out  ID_WIDTH  stream id
- m_axis_tdest  out  DEST_WIDTH  stream dest
- m_axis_tuser  out  USER_WIDTH  {USER_WIDTH{cmd_bad}} on the last beat, 0 otherwise
- busy  out  1  high in SEND or GAP
- frame_count  out  CNT_WIDTH  completed frames (last beat transferred)
- beat_count  out  CNT_WIDTH  transferred beats

Behaviour:
- Reset (synchronous, active-high, dominates all other inputs):
  - state=IDLE; cmd_ready=0 during the reset cycle, then 1.
  - m_axis_tvalid, tlast, tuser, tdata, tid, tdest = 0; busy=0; both counters=0.
- States:
  - IDLE:
    - cmd_ready=1, tvalid=0.
    - On cmd_valid&&cmd_ready: latch all cmd_* fields; load tdata=cmd_seed; load remaining=cmd_len; go to SEND.
    - tvalid=1 in the cycle after acceptance, so first-beat latency is 1 cycle.
  - SEND:
    - tvalid=1, cmd_ready=0.
    - tlast=1 exactly when remaining==0; tuser is non-zero only on that beat, and only if bad is latched.
    - On a transfer (tvalid&&tready):
      - beat_count+1
      - tdata+1, wrapping modulo 2^DATA_WIDTH
      - remaining-1
    - On a transfer with tlast:
      - frame_count+1
      - tvalid falls next cycle
      - go to GAP with gap_cnt=cmd_gap if cmd_gap!=0, else to IDLE.
  - GAP:
    - tvalid=0, cmd_ready=0.
    - gap_cnt decrements each cycle; go to IDLE when it reaches 1.
    - Exactly cmd_gap cycles are spent in GAP.
- AXIS rules:
  - While tvalid=1 and tready=0, tdata/tlast/tid/tdest/tuser hold stable and tvalid stays high.
  - tvalid never depends combinationally on tready.
  - All outputs are registered.
- Throughput:
  - 1 beat/cycle with tready held high.
  - Minimum one IDLE cycle between frames (gap=0), so back-to-back frames show exactly one tvalid-low cycle.
- Widths and boundaries:
  - cmd_len=max (2^LEN_WIDTH-1) yields 2^LEN_WIDTH beats; no overflow of remaining.
  - Counters wrap silently at 2^CNT_WIDTH.
- Simultaneous events: cmd_valid during SEND/GAP is ignored (cmd_ready=0); the command is held by the requester until IDLE.
- Reset mid-frame:
  - Abort immediately; tvalid=0 after the reset edge; no tlast is emitted for the aborted frame.
  - Counters clear. The sink is expected to be reset with the same rst.
- tkeep is not generated; tdata is always fully valid.

Test Plan:
1. Reset, then cmd len=0, seed=0x01, id=1, dest=0, bad=0, gap=0; tready=1.
   - Exactly one beat, one cycle after accept: tdata=0x01, tlast=1, tuser=0.
   - frame_count=1, beat_count=1.
2. cmd len=3, seed=0x10; tready pattern 1,0,0,1,1,0,1.
   - Beats 0x10,0x11,0x12,0x13 in order; tlast only on 0x13.
   - Outputs stable through every stall; beat_count=4.
3. cmd len=2, seed=0xFE, bad=1.
   - Beats 0xFE,0xFF,0x00 (wrap); tuser=1 only on 0x00 with tlast.
4. Two commands issued back-to-back: gap=0, then gap=3; tready=1.
   - Exactly 1 tvalid-low cycle after frame 1; 4 low cycles (3 GAP + 1 IDLE) after frame 2.
   - cmd_ready low throughout SEND/GAP.
5. cmd len=5, tready=1; assert rst for one cycle on the 3rd beat.
   - tvalid=0 from the next cycle, no tlast seen, counters=0.
   - cmd_ready=1 one cycle after rst deasserts; the next command runs normally.
6. Drive an axis_fifo (DEPTH=4, FRAME_FIFO=1, DROP_WHEN_FULL=1) with tready held high, with frames of len=0,0,0 and then a len=5 frame.
   - The 6-beat frame is dropped by the sink; the source still reports frame_count=4 and beat_count=9.
